// File: rtl/eth_tx_preamble.sv
// eth_tx_preamble: prepends PREAMBLE_LEN x 0x55 plus a 0xD5 SFD to each frame
// and enforces a minimum output inter-frame gap of IFG_BYTES idle byte-times.
// A frame that starts before the gap has elapsed is dropped whole and counted.
//
// Ports:
//   clk            master clock, rising edge
//   rst_n          asynchronous active-low reset
//   in_eth_stream  {cke, frm, dat[7:0]}; frm/dat qualified by cke
//   out_eth_stream {out_cke, out_frm, out_dat[7:0]}, fully registered
//   ifg_drop_cnt   saturating count of dropped input frames
module eth_tx_preamble #(
  parameter int unsigned PREAMBLE_LEN = 7,
  parameter int unsigned IFG_BYTES    = 12
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [9:0]  in_eth_stream,
  output logic [9:0]  out_eth_stream,
  output logic [15:0] ifg_drop_cnt
);

  localparam int unsigned D      = PREAMBLE_LEN + 1;
  localparam int unsigned PRE_W  = $clog2(PREAMBLE_LEN + 1);
  localparam int unsigned GAP_W  = $clog2(IFG_BYTES + 1);
  localparam int unsigned CNT_W  = (PRE_W > GAP_W) ? PRE_W : GAP_W;
  localparam int unsigned BEAT_W = 9;

  typedef enum logic [1:0] {IDLE, PRE, DATA, IFG} state_t;

  logic              cke;
  logic              frm;
  logic [7:0]        dat;
  logic              rise;
  logic              accept;
  logic              drop;
  logic              gated_frm;
  logic              dly_frm;
  logic [7:0]        dly_dat;

  state_t            state;
  logic              frm_prev;
  logic              acc;
  logic [CNT_W-1:0]  cnt;
  logic [D-1:0][BEAT_W-1:0] dly;
  logic              out_cke;
  logic              out_frm;
  logic [7:0]        out_dat;
  logic [15:0]       drop_cnt;

  assign cke = in_eth_stream[9];
  assign frm = in_eth_stream[8];
  assign dat = in_eth_stream[7:0];

  // Frame start detection; a start is only honoured when the FSM is idle.
  assign rise      = frm & ~frm_prev;
  assign accept    = rise & (state == IDLE);
  assign drop      = rise & (state != IDLE);
  assign gated_frm = frm & (acc | accept);

  // Oldest delay-line stage lines up with the byte after the SFD.
  assign dly_frm = dly[D-1][8];
  assign dly_dat = dly[D-1][7:0];

  assign out_eth_stream = {out_cke, out_frm, out_dat};
  assign ifg_drop_cnt   = drop_cnt;

  // All state advances on cke cycles only; out_cke is a plain 1-clk delay.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      frm_prev <= 1'b1;
      acc      <= 1'b0;
      cnt      <= '0;
      dly      <= '0;
      out_cke  <= 1'b0;
      out_frm  <= 1'b0;
      out_dat  <= 8'h00;
      drop_cnt <= 16'h0000;
    end else begin
      out_cke <= cke;
      if (cke) begin
        frm_prev <= frm;
        dly      <= {dly[D-2:0], {gated_frm, dat}};

        if (accept) begin
          acc <= 1'b1;
        end else if (!frm) begin
          acc <= 1'b0;
        end

        if (drop && (drop_cnt != 16'hFFFF)) begin
          drop_cnt <= drop_cnt + 16'd1;
        end

        case (state)
          IDLE: begin
            out_frm <= 1'b0;
            out_dat <= 8'h00;
            if (accept) begin
              out_frm <= 1'b1;
              out_dat <= 8'h55;
              cnt     <= CNT_W'(1);
              state   <= PRE;
            end
          end
          PRE: begin
            out_frm <= 1'b1;
            if (cnt < CNT_W'(PREAMBLE_LEN)) begin
              out_dat <= 8'h55;
              cnt     <= cnt + CNT_W'(1);
            end else begin
              out_dat <= 8'hD5;
              state   <= DATA;
            end
          end
          DATA: begin
            if (dly_frm) begin
              out_frm <= 1'b1;
              out_dat <= dly_dat;
            end else begin
              // This idle byte is the first of the gap.
              out_frm <= 1'b0;
              out_dat <= 8'h00;
              cnt     <= CNT_W'(1);
              state   <= (IFG_BYTES <= 1) ? IDLE : IFG;
            end
          end
          IFG: begin
            out_frm <= 1'b0;
            out_dat <= 8'h00;
            cnt     <= cnt + CNT_W'(1);
            // Leave on the edge that emits the last gap byte; a rise on this
            // same edge still sees IFG and is dropped.
            if (cnt == CNT_W'(IFG_BYTES - 1)) begin
              state <= IDLE;
            end
          end
          default: begin
            out_frm <= 1'b0;
            out_dat <= 8'h00;
            state   <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_eth_tx_preamble.sv
// tb_eth_tx_preamble: directed bench for eth_tx_preamble. Output beats are
// captured on every out_cke, split into frames and gaps, and compared with
// hand-derived expectations (7 x 0x55, 0xD5, then the input bytes).
module tb_eth_tx_preamble;

  logic        clk;
  logic        rst_n;
  logic [9:0]  in_eth_stream;
  logic [9:0]  out_eth_stream;
  logic [15:0] ifg_drop_cnt;

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;

  logic [8:0] cap_q[$];
  logic [7:0] fr_data[$];
  int         fr_start[$];
  int         fr_len[$];
  int         fr_gap[$];

  int         rise_cyc;
  int         first_out_cyc;
  bit         seen_frm;
  int         cke_err;
  int         hold_err;
  int         zero_err;
  logic       cke_d;
  logic [8:0] last_out;

  eth_tx_preamble #(
    .PREAMBLE_LEN(7),
    .IFG_BYTES   (12)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_eth_stream (in_eth_stream),
    .out_eth_stream(out_eth_stream),
    .ifg_drop_cnt  (ifg_drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference 1-clk delay of in_cke for the out_cke comparison.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cke_d <= 1'b0;
    else        cke_d <= in_eth_stream[9];
  end

  // Output monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      last_out = 9'h000;
    end else begin
      if (out_eth_stream[9] !== cke_d) cke_err++;
      if (!out_eth_stream[9] && (out_eth_stream[8:0] !== last_out)) hold_err++;
      if (!out_eth_stream[8] && (out_eth_stream[7:0] !== 8'h00)) zero_err++;
      if (out_eth_stream[9]) begin
        cap_q.push_back(out_eth_stream[8:0]);
        last_out = out_eth_stream[8:0];
      end
      if (out_eth_stream[8] && !seen_frm) begin
        seen_frm      = 1'b1;
        first_out_cyc = cyc;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic step(input logic c, input logic f, input logic [7:0] d);
    @(negedge clk);
    in_eth_stream = {c, f, d};
  endtask

  task automatic clear_mon();
    cap_q.delete();
    seen_frm = 1'b0;
    cke_err  = 0;
    hold_err = 0;
    zero_err = 0;
  endtask

  // n cke byte-times of idle; non-cke filler carries frm=1 to prove qualification.
  task automatic send_idle(input int n, input int div);
    for (int i = 0; i < n; i++) begin
      step(1'b1, 1'b0, 8'h00);
      for (int k = 1; k < div; k++) step(1'b0, 1'b1, 8'hEE);
    end
  endtask

  // Frame of len bytes base, base+1, ...; non-cke filler carries frm=0.
  task automatic send_frame(input int len, input logic [7:0] base, input int div);
    for (int i = 0; i < len; i++) begin
      step(1'b1, 1'b1, 8'(int'(base) + i));
      if (i == 0) rise_cyc = cyc;
      for (int k = 1; k < div; k++) step(1'b0, 1'b0, 8'hEE);
    end
  endtask

  // Split captured beats into frames and the idle count preceding each.
  task automatic parse();
    int lows;
    bit in_f;
    fr_data.delete(); fr_start.delete(); fr_len.delete(); fr_gap.delete();
    lows = 0;
    in_f = 1'b0;
    foreach (cap_q[i]) begin
      if (cap_q[i][8]) begin
        if (!in_f) begin
          fr_start.push_back(fr_data.size());
          fr_len.push_back(0);
          fr_gap.push_back(lows);
          in_f = 1'b1;
        end
        fr_data.push_back(cap_q[i][7:0]);
        fr_len[fr_len.size()-1]++;
      end else begin
        if (in_f) lows = 0;
        in_f = 1'b0;
        lows++;
      end
    end
  endtask

  task automatic check_frame(input string tag, input int idx, input int len, input logic [7:0] base);
    int n;
    logic [7:0] exp;
    if (idx >= fr_len.size()) return;
    check($sformatf("%s_len", tag), 32'(fr_len[idx]), 32'(len + 8));
    n = (fr_len[idx] < len + 8) ? fr_len[idx] : len + 8;
    for (int j = 0; j < n; j++) begin
      if (j < 7)       exp = 8'h55;
      else if (j == 7) exp = 8'hD5;
      else             exp = 8'(int'(base) + j - 8);
      check($sformatf("%s_b%0d", tag, j), 32'(fr_data[fr_start[idx] + j]), 32'(exp));
    end
  endtask

  initial begin
    in_eth_stream = 10'h000;
    rst_n         = 1'b0;
    clear_mon();
    repeat (3) @(negedge clk);
    check("rst_out", 32'(out_eth_stream), 32'h0);
    check("rst_cnt", 32'(ifg_drop_cnt), 32'h0);
    rst_n = 1'b1;

    // 64-byte frame, cke every cycle.
    clear_mon();
    send_idle(2, 1);
    send_frame(64, 8'h00, 1);
    send_idle(30, 1);
    parse();
    check("t1_nfrm", 32'(fr_len.size()), 32'd1);
    check_frame("t1", 0, 64, 8'h00);
    check("t1_lat", 32'(first_out_cyc - rise_cyc), 32'd1);
    check("t1_cnt", 32'(ifg_drop_cnt), 32'd0);
    check("t1_zero", 32'(zero_err), 32'd0);

    // Same frame, cke one cycle in four.
    clear_mon();
    send_idle(2, 4);
    send_frame(64, 8'h00, 4);
    send_idle(30, 4);
    parse();
    check("t2_nfrm", 32'(fr_len.size()), 32'd1);
    check_frame("t2", 0, 64, 8'h00);
    check("t2_lat", 32'(first_out_cyc - rise_cyc), 32'd1);
    check("t2_cke", 32'(cke_err), 32'd0);
    check("t2_hold", 32'(hold_err), 32'd0);
    check("t2_cnt", 32'(ifg_drop_cnt), 32'd0);

    // Gap 20 accepted, gap 19 dropped, then a well-spaced frame.
    clear_mon();
    send_frame(10, 8'h10, 1); send_idle(20, 1);
    send_frame(10, 8'h30, 1); send_idle(19, 1);
    send_frame(10, 8'h50, 1); send_idle(20, 1);
    send_frame(10, 8'h70, 1); send_idle(30, 1);
    parse();
    check("t3_nfrm", 32'(fr_len.size()), 32'd3);
    check_frame("t3a", 0, 10, 8'h10);
    check_frame("t3b", 1, 10, 8'h30);
    check_frame("t3d", 2, 10, 8'h70);
    if (fr_gap.size() == 3) begin
      check("t3_gap_ab", 32'(fr_gap[1]), 32'd12);
      check("t3_gap_bd", 32'(fr_gap[2]), 32'd41);
    end
    check("t3_cnt", 32'(ifg_drop_cnt), 32'd1);
    check("t3_zero", 32'(zero_err), 32'd0);

    // Rises during DATA and IFG are dropped once per frame.
    clear_mon();
    send_frame(20, 8'h90, 1); send_idle(3, 1);
    send_frame(5, 8'hC0, 1);
    check("t4_cnt_f", 32'(ifg_drop_cnt), 32'd2);
    send_idle(3, 1);
    send_frame(5, 8'hD0, 1);  send_idle(25, 1);
    send_frame(4, 8'hE0, 1);  send_idle(30, 1);
    parse();
    check("t4_nfrm", 32'(fr_len.size()), 32'd2);
    check_frame("t4e", 0, 20, 8'h90);
    check_frame("t4h", 1, 4, 8'hE0);
    check("t4_cnt", 32'(ifg_drop_cnt), 32'd3);

    // Reset mid-preamble, released while the input frame is still active.
    clear_mon();
    step(1'b1, 1'b1, 8'h11);
    step(1'b1, 1'b1, 8'h12);
    step(1'b1, 1'b1, 8'h13);
    #2 rst_n = 1'b0;
    #1;
    check("t5_rst_out", 32'(out_eth_stream), 32'h0);
    check("t5_rst_cnt", 32'(ifg_drop_cnt), 32'h0);
    step(1'b1, 1'b1, 8'h14);
    step(1'b1, 1'b1, 8'h15);
    rst_n = 1'b1;
    clear_mon();
    for (int i = 0; i < 10; i++) step(1'b1, 1'b1, 8'(8'h16 + i));
    send_idle(20, 1);
    send_frame(6, 8'hA0, 1);
    send_idle(30, 1);
    parse();
    check("t5_nfrm", 32'(fr_len.size()), 32'd1);
    check_frame("t5", 0, 6, 8'hA0);
    check("t5_cnt", 32'(ifg_drop_cnt), 32'd0);

    // Counter saturation, with a single-byte frame keeping the FSM busy.
    clear_mon();
    send_idle(5, 1);
    force dut.drop_cnt = 16'hFFFD;
    #1;
    release dut.drop_cnt;
    send_frame(1, 8'h5A, 1);
    step(1'b1, 1'b0, 8'h00);
    step(1'b1, 1'b1, 8'h01);
    step(1'b1, 1'b0, 8'h00);
    check("t6_cnt1", 32'(ifg_drop_cnt), 32'hFFFE);
    step(1'b1, 1'b1, 8'h01);
    step(1'b1, 1'b0, 8'h00);
    check("t6_cnt2", 32'(ifg_drop_cnt), 32'hFFFF);
    step(1'b1, 1'b1, 8'h01);
    step(1'b1, 1'b0, 8'h00);
    check("t6_cnt3", 32'(ifg_drop_cnt), 32'hFFFF);
    step(1'b1, 1'b1, 8'h01);
    step(1'b1, 1'b0, 8'h00);
    check("t6_cnt4", 32'(ifg_drop_cnt), 32'hFFFF);
    send_idle(40, 1);
    parse();
    check("t6_nfrm", 32'(fr_len.size()), 32'd1);
    check_frame("t6", 0, 1, 8'h5A);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
